// File: rtl/time_counter.sv
// BCD 24-hour real-time clock with button-driven time setting.
// Feeds HH:MM:SS, set mode, blink and hour chime to the display driver.
module time_counter #(
    parameter int TICK_DIV = 1000
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       mode_key,
    input  logic       adj_key,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [1:0] set_mode,
    output logic       blink,
    output logic       hour_chime
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);

    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] SET_H = 2'b01;
    localparam logic [1:0] SET_M = 2'b10;
    localparam logic [1:0] SET_S = 2'b11;

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic          mode_d;
    logic          adj_d;
    logic          mode_p;
    logic          adj_p;
    logic [1:0]    mode_n;
    logic [7:0]    hour_n;
    logic [7:0]    minute_n;
    logic [7:0]    second_n;
    logic          chime_n;
    logic          blink_n;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5)
                r = 8'h00;
            else
                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // A mode edge always wins; any adj edge in the same cycle is dropped.
    always_comb begin
        mode_n   = set_mode;
        presc_n  = presc;
        hour_n   = hour;
        minute_n = minute;
        second_n = second;
        chime_n  = 1'b0;
        if (mode_p) begin
            mode_n  = set_mode + 2'd1;
            presc_n = '0;
        end else begin
            unique case (set_mode)
                RUN: begin
                    if (presc == LAST) begin
                        presc_n  = '0;
                        second_n = inc60(second);
                        if (second == 8'h59) begin
                            minute_n = inc60(minute);
                            if (minute == 8'h59) begin
                                hour_n  = inc24(hour);
                                chime_n = 1'b1;
                            end
                        end
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                end
                SET_H: begin
                    presc_n = '0;
                    if (adj_p)
                        hour_n = inc24(hour);
                end
                SET_M: begin
                    presc_n = '0;
                    if (adj_p)
                        minute_n = inc60(minute);
                end
                SET_S: begin
                    presc_n = '0;
                    if (adj_p)
                        second_n = inc60(second);
                end
                default: begin
                    presc_n = '0;
                end
            endcase
        end
        blink_n = (presc_n < HALF);
    end

    always_ff @(posedge CP) begin
        if (!nCR) begin
            presc      <= '0;
            mode_d     <= 1'b1;
            adj_d      <= 1'b1;
            mode_p     <= 1'b0;
            adj_p      <= 1'b0;
            set_mode   <= RUN;
            hour       <= 8'h00;
            minute     <= 8'h00;
            second     <= 8'h00;
            blink      <= 1'b1;
            hour_chime <= 1'b0;
        end else begin
            presc      <= presc_n;
            mode_d     <= mode_key;
            adj_d      <= adj_key;
            mode_p     <= mode_key & ~mode_d;
            adj_p      <= adj_key & ~adj_d;
            set_mode   <= mode_n;
            hour       <= hour_n;
            minute     <= minute_n;
            second     <= second_n;
            blink      <= blink_n;
            hour_chime <= chime_n;
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter with TICK_DIV=4.
// Keys change and outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_time_counter;

    logic       CP;
    logic       nCR;
    logic       mode_key;
    logic       adj_key;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [1:0] set_mode;
    logic       blink;
    logic       hour_chime;

    int checks;
    int failures;

    time_counter #(.TICK_DIV(4)) dut (
        .CP(CP),
        .nCR(nCR),
        .mode_key(mode_key),
        .adj_key(adj_key),
        .hour(hour),
        .minute(minute),
        .second(second),
        .set_mode(set_mode),
        .blink(blink),
        .hour_chime(hour_chime)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic step(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic press(input logic m, input logic a);
        mode_key = m;
        adj_key  = a;
        step(1);
        mode_key = 1'b0;
        adj_key  = 1'b0;
        step(1);
    endtask

    task automatic presses(input int n, input logic m, input logic a);
        for (int i = 0; i < n; i++)
            press(m, a);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hms();
        return {8'h00, hour, minute, second};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        nCR      = 1'b0;
        mode_key = 1'b1;
        adj_key  = 1'b0;

        // reset held with mode key high
        step(3);
        chk("rst_time", hms(), 32'h000000);
        chk("rst_mode", {30'd0, set_mode}, 32'd0);
        chk("rst_blink", {31'd0, blink}, 32'd1);
        chk("rst_chime", {31'd0, hour_chime}, 32'd0);
        nCR = 1'b1;
        step(2);
        chk("rst_key_held", {30'd0, set_mode}, 32'd0);
        mode_key = 1'b0;
        step(1);

        // clean reset, then blink pattern and seconds carry
        nCR = 1'b0;
        step(1);
        nCR = 1'b1;
        chk("blink_p0", {31'd0, blink}, 32'd1);
        step(1);
        chk("blink_p1", {31'd0, blink}, 32'd1);
        step(1);
        chk("blink_p2", {31'd0, blink}, 32'd0);
        step(1);
        chk("blink_p3", {31'd0, blink}, 32'd0);
        step(1);
        chk("first_tick", hms(), 32'h000001);
        chk("blink_wrap", {31'd0, blink}, 32'd1);
        step(236);
        chk("sec_carry", hms(), 32'h000100);
        chk("sec_carry_chime", {31'd0, hour_chime}, 32'd0);

        // set 23:59:59
        press(1'b1, 1'b0);
        chk("enter_seth", {30'd0, set_mode}, 32'd1);
        chk("set_blink", {31'd0, blink}, 32'd1);
        presses(23, 1'b0, 1'b1);
        chk("hour_23", hms(), 32'h230100);
        press(1'b0, 1'b1);
        chk("hour_wrap", hms(), 32'h000100);
        presses(23, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        chk("enter_setm", {30'd0, set_mode}, 32'd2);
        presses(58, 1'b0, 1'b1);
        chk("min_59", hms(), 32'h235900);
        press(1'b1, 1'b0);
        chk("enter_sets", {30'd0, set_mode}, 32'd3);
        presses(59, 1'b0, 1'b1);
        chk("sec_59", hms(), 32'h235959);
        press(1'b1, 1'b0);
        chk("back_run", {30'd0, set_mode}, 32'd0);
        step(3);
        chk("pre_roll", hms(), 32'h235959);
        chk("pre_roll_chime", {31'd0, hour_chime}, 32'd0);
        step(1);
        chk("full_roll", hms(), 32'h000000);
        chk("roll_chime", {31'd0, hour_chime}, 32'd1);
        step(1);
        chk("chime_one", {31'd0, hour_chime}, 32'd0);

        // 09:59:59 -> 10:00:00
        press(1'b1, 1'b0);
        presses(9, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        presses(59, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        presses(59, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        step(3);
        chk("pre_ten", hms(), 32'h095959);
        step(1);
        chk("roll_ten", hms(), 32'h100000);
        chk("ten_chime", {31'd0, hour_chime}, 32'd1);
        step(1);
        chk("ten_chime_off", {31'd0, hour_chime}, 32'd0);

        // minute wrap without carry into hour
        press(1'b1, 1'b0);
        presses(19, 1'b0, 1'b1);
        chk("hour_05", hms(), 32'h050000);
        press(1'b1, 1'b0);
        presses(59, 1'b0, 1'b1);
        chk("min_59_h05", hms(), 32'h055900);
        press(1'b0, 1'b1);
        chk("min_wrap", hms(), 32'h050000);
        chk("min_wrap_chime", {31'd0, hour_chime}, 32'd0);
        step(10);
        chk("frozen", hms(), 32'h050000);

        // mode cycling and adj ignored in RUN
        presses(2, 1'b1, 1'b0);
        chk("cyc_run", {30'd0, set_mode}, 32'd0);
        press(1'b1, 1'b0);
        chk("cyc_01", {30'd0, set_mode}, 32'd1);
        press(1'b1, 1'b0);
        chk("cyc_10", {30'd0, set_mode}, 32'd2);
        press(1'b1, 1'b0);
        chk("cyc_11", {30'd0, set_mode}, 32'd3);
        press(1'b1, 1'b0);
        chk("cyc_00", {30'd0, set_mode}, 32'd0);
        press(1'b0, 1'b1);
        chk("run_adj_ign", hms(), 32'h050000);

        // simultaneous mode/adj, then held adj
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        chk("prio_mode", {30'd0, set_mode}, 32'd2);
        chk("prio_hour", {24'd0, hour}, 32'h05);
        adj_key = 1'b1;
        step(10);
        adj_key = 1'b0;
        step(1);
        chk("held_adj", hms(), 32'h050100);

        // reset in SET_S at 12:34:56
        press(1'b1, 1'b0);
        presses(56, 1'b0, 1'b1);
        presses(2, 1'b1, 1'b0);
        presses(7, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        presses(33, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        chk("mid_set_time", hms(), 32'h123456);
        chk("mid_set_mode", {30'd0, set_mode}, 32'd3);
        nCR = 1'b0;
        step(1);
        nCR = 1'b1;
        chk("mid_rst_time", hms(), 32'h000000);
        chk("mid_rst_mode", {30'd0, set_mode}, 32'd0);
        chk("mid_rst_blink", {31'd0, blink}, 32'd1);
        step(3);
        chk("resume_wait", hms(), 32'h000000);
        step(1);
        chk("resume_tick", hms(), 32'h000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
BCD real-time clock core that produces the hour/minute/second buses consumed by the seven-segment scan display driver.
- Divides CP down to a 1 s tick and keeps a 24-hour HH:MM:SS time in packed BCD.
- Supports manual time setting through two debounced push-button inputs (mode, adjust) with a small set-mode state machine.
- Sits between the board clock/buttons and the display driver.

Parameters:
TICK_DIV, 1000, CP cycles per 1 s tick; must be ≥2 (sim uses 4)

Ports:
CP  input  1  system clock; all logic on rising edge
nCR  input  1  synchronous active-low reset
mode_key  input  1  debounced mode button, active-high level
adj_key  input  1  debounced adjust button, active-high level
hour  output  8  BCD hours, [7:4] tens (0-2), [3:0] units
minute  output  8  BCD minutes, [7:4] tens (0-5), [3:0] units
second  output  8  BCD seconds, [7:4] tens (0-5), [3:0] units
set_mode  output  2  00 RUN, 01 SET_H, 10 SET_M, 11 SET_S
blink  output  1  high for first half of each second (prescaler < TICK_DIV/2)
hour_chime  output  1  one-cycle pulse on hour rollover in RUN

Behaviour:
- Reset: when nCR=0 at a CP edge, the following take effect on that edge:
  - hour=minute=second=8'h00, set_mode=00 (RUN), prescaler=0, hour_chime=0.
  - Key-history registers are set to 1, so a key held through reset produces no edge.
  - blink=1, since it derives from prescaler=0.
- Prescaler:
  - In RUN it counts 0..TICK_DIV-1 and wraps to 0.
  - tick is asserted when prescaler==TICK_DIV-1.
  - In any SET state the prescaler is held at 0.
- Key edges:
  - edge = key & ~key_d, where key_d is registered every cycle.
  - An edge on cycle N updates the outputs at the edge ending cycle N+1, i.e. one registered stage.
- FSM transitions:
  - A mode edge steps RUN→SET_H→SET_M→SET_S→RUN.
  - Leaving SET_S restarts counting with the prescaler at 0.
- Simultaneous mode and adj edges: mode wins; the adj edge is discarded.
- RUN counting:
  - On tick, second increments in BCD: units 9→0 with tens+1; 59→00 carries to minute.
  - minute 59→00 carries to hour.
  - hour counts 09→10, 19→20, 23→00.
  - A full-carry tick 23:59:59 produces 00:00:00 in one cycle.
- hour_chime is 1 for exactly the one cycle in which minute and second become 00 via a carry. It is never asserted by SET adjustments.
- SET states:
  - An adj edge increments only the selected field, wrapping hour 23→00 and minute/second 59→00.
  - No carry into other fields.
  - adj edges in RUN are ignored.
- Invariants:
  - All outputs are registered.
  - No invalid BCD digit ever appears on any bus, including after reset or mid-set.
- Reset mid-operation (any state, any count): returns to 00:00:00 RUN on the same edge.

Test Plan:
- Reset: TICK_DIV=4; hold nCR=0 for 3 cycles with mode_key=1 → 00:00:00, set_mode=00; release with mode_key still 1 → set_mode stays 00.
- Seconds carry: run from 00:00:00 for 4×60 cycles → second=00, minute=01; blink period is 4 cycles, high for 2.
- Full rollover: set 23:59:59 (via SET_H/M/S adj presses), return to RUN, wait 4 cycles → 00:00:00 and hour_chime high exactly 1 cycle; repeat from 09:59:59 → 10:00:00.
- SET wrap without carry: in SET_M with minute=59 and hour=05, one adj press → minute=00, hour=05; in SET_H with 23, one press → 00; time frozen throughout SET states.
- Mode cycling and priority: 4 mode presses → set_mode 01,10,11,00; mode and adj rising on the same cycle in SET_H → set_mode=10, hour unchanged; held adj key (10 cycles high) → exactly one increment.
- Reset mid-set: in SET_S at 12:34:56, pulse nCR=0 for 1 cycle → 00:00:00, set_mode=00, counting resumes 4 cycles later with second=01.
